// File: rtl/sort_three_floats_seq_if.sv
// Stream bundle for the three-float sorter: word-per-beat input stream and
// sorted-triple output stream, both valid/ready.
interface sort_three_floats_seq_if #(
    parameter int FLEN = 64
);
    logic                  up_valid;
    logic [FLEN-1:0]       up_data;
    logic                  up_ready;
    logic                  down_valid;
    logic [0:2][FLEN-1:0]  down_data;
    logic                  down_err;
    logic                  down_ready;

    modport master (
        output up_valid, up_data, down_ready,
        input  up_ready, down_valid, down_data, down_err
    );

    modport slave (
        input  up_valid, up_data, down_ready,
        output up_ready, down_valid, down_data, down_err
    );
endinterface

// File: rtl/sort_three_floats_seq.sv
// Collects three binary64 words, sorts them ascending with one shared
// compare-swap unit over three cycles, and hands the triple downstream.
module sort_three_floats_seq #(
    parameter int FLEN = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    sort_three_floats_seq_if.slave   bus
);
    localparam int NE = 11;

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        CMP01   = 3'd1,
        CMP12   = 3'd2,
        CMP01B  = 3'd3,
        OUT     = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           count_q, count_d;
    logic                 err_q, err_d;
    logic                 down_valid_q, down_valid_d;
    logic                 down_err_q, down_err_d;
    logic [0:2][FLEN-1:0] down_data_q, down_data_d;
    logic [FLEN-1:0]      slot_q [3];
    logic [FLEN-1:0]      slot_d [3];

    logic                 accept;
    logic                 pair_hi;
    logic [FLEN-1:0]      cmp_a, cmp_b;
    logic                 cmp_swap;

    // Inf and NaN both have an all-ones exponent field.
    function automatic logic is_err(input logic [FLEN-1:0] w);
        return &w[FLEN-2 -: NE];
    endfunction

    function automatic logic float_gt(input logic [FLEN-1:0] a, input logic [FLEN-1:0] b);
        logic [FLEN-2:0] ma;
        logic [FLEN-2:0] mb;
        logic            gt;
        ma = a[FLEN-2:0];
        mb = b[FLEN-2:0];
        if (a[FLEN-1] != b[FLEN-1]) begin
            // -0 and +0 compare equal, so a sign difference alone is not enough.
            gt = !a[FLEN-1] && ((ma | mb) != '0);
        end else if (!a[FLEN-1]) begin
            gt = ma > mb;
        end else begin
            gt = ma < mb;
        end
        return gt;
    endfunction

    assign accept   = bus.up_valid && (state_q == COLLECT);
    assign pair_hi  = (state_q == CMP12);
    assign cmp_a    = pair_hi ? slot_q[1] : slot_q[0];
    assign cmp_b    = pair_hi ? slot_q[2] : slot_q[1];
    assign cmp_swap = float_gt(cmp_a, cmp_b);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        err_d        = err_q;
        down_valid_d = down_valid_q;
        down_err_d   = down_err_q;
        down_data_d  = down_data_q;
        slot_d       = slot_q;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    err_d = err_q | is_err(bus.up_data);
                    case (count_q)
                        2'd0:    slot_d[0] = bus.up_data;
                        2'd1:    slot_d[1] = bus.up_data;
                        default: slot_d[2] = bus.up_data;
                    endcase
                    if (count_q == 2'd2) begin
                        count_d = 2'd0;
                        state_d = err_d ? OUT : CMP01;
                    end else begin
                        count_d = count_q + 2'd1;
                    end
                end
            end

            CMP01, CMP12, CMP01B: begin
                if (cmp_swap) begin
                    if (pair_hi) begin
                        slot_d[1] = cmp_b;
                        slot_d[2] = cmp_a;
                    end else begin
                        slot_d[0] = cmp_b;
                        slot_d[1] = cmp_a;
                    end
                end
                case (state_q)
                    CMP01:   state_d = CMP12;
                    CMP12:   state_d = CMP01B;
                    default: state_d = OUT;
                endcase
            end

            OUT: begin
                // First OUT cycle registers the result; it is then held until taken.
                if (!down_valid_q) begin
                    down_valid_d   = 1'b1;
                    down_err_d     = err_q;
                    down_data_d[0] = slot_q[0];
                    down_data_d[1] = slot_q[1];
                    down_data_d[2] = slot_q[2];
                end else if (bus.down_ready) begin
                    down_valid_d = 1'b0;
                    err_d        = 1'b0;
                    state_d      = COLLECT;
                end
            end

            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= COLLECT;
            count_q      <= 2'd0;
            err_q        <= 1'b0;
            down_valid_q <= 1'b0;
            down_err_q   <= 1'b0;
            down_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            err_q        <= err_d;
            down_valid_q <= down_valid_d;
            down_err_q   <= down_err_d;
            down_data_q  <= down_data_d;
        end
    end

    // Slots need no reset: count restarts at 0 so every slot is rewritten first.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    assign bus.up_ready   = (state_q == COLLECT);
    assign bus.down_valid = down_valid_q;
    assign bus.down_err   = down_err_q;
    assign bus.down_data  = down_data_q;
endmodule
